// File: rtl/nexys_starship_spawner.sv
// Spawn scheduler feeding the four lane monster state machines with one-cycle *_random requests.
// Optional build macro NEXYS_SPAWN_BURST_EN: at level 3 one spawn event may fill two lanes.
module nexys_starship_spawner #(
    parameter int TICK_DIV        = 500000,
    parameter int BASE_INTERVAL   = 400,
    parameter int LEVEL_STEP      = 100,
    parameter int MIN_INTERVAL    = 100,
    parameter int LEVEL_UP_SPAWNS = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       game_over,
    input  logic [3:0] lane_full,
    output logic       top_random,
    output logic       bottom_random,
    output logic       left_random,
    output logic       right_random,
    output logic [1:0] level,
    output logic       spawn_busy
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic signed [13:0] BASE_S     = 14'(BASE_INTERVAL);
    localparam logic signed [13:0] STEP_S     = 14'(LEVEL_STEP);
    localparam logic signed [13:0] MIN_S      = 14'(MIN_INTERVAL);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, PICK, SPAWN} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        lfsr_reg;
    logic [PW-1:0]      presc_reg;
    logic [11:0]        interval_reg;
    logic [3:0]         spawn_cnt_reg;
    logic [1:0]         level_reg;
    logic [3:0]         rand_reg, rand_next;
    logic               busy_reg;
    logic               tick;
    logic [3:0]         probe_free;
    logic [3:0]         pick_vec;
    logic [1:0]         pick_limit;
    logic [1:0]         probe_idx;
    logic [1:0]         found;
    logic signed [13:0] lvl_raw, lvl_int;
    logic [4:0]         spawn_inc;

    // Free-running so spawn patterns depend on when the player acts.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            lfsr_reg <= 16'hACE1;
        else
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end

    assign tick = (state_reg == WAIT) && (presc_reg == PRESC_LAST);

    // Signed so that a level step past the base clamps to the floor instead of wrapping.
    assign lvl_raw   = BASE_S - $signed({12'd0, level_reg}) * STEP_S;
    assign lvl_int   = (lvl_raw < MIN_S) ? MIN_S : lvl_raw;
    assign spawn_inc = {1'b0, spawn_cnt_reg} + 5'd1;

`ifdef NEXYS_SPAWN_BURST_EN
    assign pick_limit = (level_reg == 2'd3) ? 2'd2 : 2'd1;
`else
    assign pick_limit = 2'd1;
`endif

    // probe_free[k] is lane (start + k) mod 4, i.e. lanes in probe order.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_probe
            assign probe_free[gi] = ~lane_full[lfsr_reg[1:0] + 2'(gi)];
        end
    endgenerate

    always_comb begin
        pick_vec  = 4'd0;
        found     = 2'd0;
        probe_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            probe_idx = lfsr_reg[1:0] + 2'(k);
            if (probe_free[k] && (found != pick_limit)) begin
                pick_vec[probe_idx] = 1'b1;
                found = found + 2'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (play_flag) state_next = LOAD;
            LOAD:    state_next = WAIT;
            WAIT:    if (tick && interval_reg == 12'd1) state_next = PICK;
            PICK:    state_next = (pick_vec != 4'd0) ? SPAWN : LOAD;
            SPAWN:   state_next = LOAD;
            default: state_next = IDLE;
        endcase
        if (game_over)
            state_next = IDLE;
        rand_next = (state_reg == PICK && !game_over) ? pick_vec : 4'd0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            interval_reg  <= 12'd0;
            spawn_cnt_reg <= 4'd0;
            level_reg     <= 2'd0;
            rand_reg      <= 4'd0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            rand_reg  <= rand_next;
            busy_reg  <= (state_next != IDLE);
            // Restarting the prescaler on WAIT entry keeps each interval an exact tick multiple.
            presc_reg <= (tick || state_reg != WAIT) ? '0 : presc_reg + PW'(1);
            if (state_next == IDLE) begin
                interval_reg  <= 12'd0;
                spawn_cnt_reg <= 4'd0;
                level_reg     <= 2'd0;
            end else begin
                case (state_reg)
                    LOAD: interval_reg <= 12'(lvl_int + 14'(lfsr_reg[7:2]));
                    WAIT: if (tick) interval_reg <= interval_reg - 12'd1;
                    SPAWN: begin
                        if (spawn_inc == 5'(LEVEL_UP_SPAWNS) && level_reg != 2'd3) begin
                            level_reg     <= level_reg + 2'd1;
                            spawn_cnt_reg <= 4'd0;
                        end else if (spawn_inc <= 5'(LEVEL_UP_SPAWNS)) begin
                            spawn_cnt_reg <= spawn_inc[3:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign top_random    = rand_reg[0];
    assign bottom_random = rand_reg[1];
    assign left_random   = rand_reg[2];
    assign right_random  = rand_reg[3];
    assign level         = level_reg;
    assign spawn_busy    = busy_reg;

endmodule

// File: tb/tb_nexys_starship_spawner.sv
// Bench for nexys_starship_spawner: event-scheduled reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_nexys_starship_spawner;
    localparam int TD   = 2;
    localparam int BASE = 400;
    localparam int STEP = 100;
    localparam int MINI = 100;
    localparam int LUS  = 8;
`ifdef NEXYS_SPAWN_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       play_flag = 1'b0;
    logic       game_over = 1'b0;
    logic [3:0] lane_full = 4'd0;
    logic       top_random, bottom_random, left_random, right_random, spawn_busy;
    logic [1:0] level;
    logic       s_top, s_bottom, s_left, s_right, s_busy;
    logic [1:0] s_level;

    always #5 Clk = ~Clk;

    nexys_starship_spawner #(
        .TICK_DIV(TD), .BASE_INTERVAL(BASE), .LEVEL_STEP(STEP),
        .MIN_INTERVAL(MINI), .LEVEL_UP_SPAWNS(LUS)
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
        .lane_full(lane_full), .top_random(top_random), .bottom_random(bottom_random),
        .left_random(left_random), .right_random(right_random), .level(level),
        .spawn_busy(spawn_busy)
    );

    // Short-interval instance used only for the first-pulse timing scenario.
    nexys_starship_spawner #(
        .TICK_DIV(4), .BASE_INTERVAL(10), .LEVEL_STEP(3),
        .MIN_INTERVAL(4), .LEVEL_UP_SPAWNS(8)
    ) u_small (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
        .lane_full(lane_full), .top_random(s_top), .bottom_random(s_bottom),
        .left_random(s_left), .right_random(s_right), .level(s_level),
        .spawn_busy(s_busy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int lvl_interval(input int lvl, input logic [15:0] l);
        int b;
        b = BASE - lvl * STEP;
        if (b < MINI) b = MINI;
        return b + int'(l[7:2]);
    endfunction

    function automatic logic [3:0] choose(input logic [1:0] s, input logic [3:0] full, input int lvl);
        int want;
        int idx;
        logic [3:0] v;
        want = (BURST && lvl == 3) ? 2 : 1;
        v = 4'd0;
        for (int k = 0; k < 4; k++) begin
            idx = (int'(s) + k) % 4;
            if (!full[idx] && want > 0) begin
                v[idx] = 1'b1;
                want--;
            end
        end
        return v;
    endfunction

    function automatic int lvl_after(input int n);
        if (n >= 24) return 3;
        if (n >= 16) return 2;
        if (n >= 8)  return 1;
        return 0;
    endfunction

    // Reference model: cycle k is the cycle following the k-th edge after reset release.
    // Each spawn event is scheduled by absolute cycle number from the interval rule.
    int          cyc = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [15:0] lfsr_at [0:299];
    bit          m_active = 1'b0;
    int          m_level = 0;
    int          m_cnt = 0;
    int          load_at = -1;
    int          pick_at = -1;
    int          spawn_at = -1;
    int          n_skipped = 0;
    int          n_spawned = 0;
    logic [3:0]  exp_rand = 4'd0;
    logic [1:0]  exp_level;
    logic        exp_busy;

    assign exp_level = 2'(m_level);
    assign exp_busy  = m_active;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc <= 0; m_lfsr <= 16'hACE1; m_active <= 1'b0; m_level <= 0; m_cnt <= 0;
            load_at <= -1; pick_at <= -1; spawn_at <= -1;
            n_skipped <= 0; n_spawned <= 0; exp_rand <= 4'd0;
        end else begin
            exp_rand <= 4'd0;
            if (game_over) begin
                m_active <= 1'b0; m_level <= 0; m_cnt <= 0;
            end else if (!m_active) begin
                if (play_flag) begin
                    m_active <= 1'b1;
                    load_at  <= cyc + 1;
                end
            end else if (cyc == load_at) begin
                pick_at <= cyc + 1 + lvl_interval(m_level, m_lfsr) * TD;
            end else if (cyc == pick_at) begin
                if (choose(m_lfsr[1:0], lane_full, m_level) == 4'd0) begin
                    load_at   <= cyc + 1;
                    n_skipped <= n_skipped + 1;
                end else begin
                    spawn_at <= cyc + 1;
                    exp_rand <= choose(m_lfsr[1:0], lane_full, m_level);
                end
            end else if (cyc == spawn_at) begin
                n_spawned <= n_spawned + 1;
                load_at   <= cyc + 1;
                if (m_cnt + 1 == LUS && m_level < 3) begin
                    m_level <= m_level + 1;
                    m_cnt   <= 0;
                end else if (m_cnt < LUS) begin
                    m_cnt <= m_cnt + 1;
                end
            end
            if (cyc < 300) lfsr_at[cyc] <= m_lfsr;
            cyc    <= cyc + 1;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    // Every-cycle comparison of all main-instance outputs against the model.
    initial forever begin
        @(negedge Clk);
        check($sformatf("cyc%0d_outputs", cyc),
              int'({25'd0, right_random, left_random, bottom_random, top_random, level, spawn_busy}),
              int'({25'd0, exp_rand, exp_level, exp_busy}));
    end

    int         s_first_at = -1;
    logic [3:0] s_first_vec = 4'd0;
    initial forever begin
        @(negedge Clk);
        if (!Reset && s_first_at < 0 && {s_right, s_left, s_bottom, s_top} != 4'd0) begin
            s_first_at  = cyc;
            s_first_vec = {s_right, s_left, s_bottom, s_top};
        end
    end

    int n_pulses = 0;
    task automatic wait_pulse(input int budget, output logic [3:0] vec, output int at);
        vec = 4'd0;
        at  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if ({right_random, left_random, bottom_random, top_random} != 4'd0) begin
                vec = {right_random, left_random, bottom_random, top_random};
                at  = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pulse_timeout: no pulse within %0d cycles, want one", budget);
        end else begin
            n_pulses++;
            $display("pulse %0d: cyc %0d lanes(RLBT)=%b level=%0d", n_pulses, at, vec, level);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached before the scenario list completed");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] vec;
        int         at;
        int         base;
        int         pulses;
        int         busy_low;
        bit         found;

        repeat (3) @(negedge Clk);
        check("reset_outputs",
              int'({right_random, left_random, bottom_random, top_random, level, spawn_busy}), 0);
        check("reset_small_busy", int'(s_busy), 0);

        // First spawn: LOAD jitter is lfsr 16'h59C3 -> [7:2] = 48.
        Reset = 1'b0;
        play_flag = 1'b1;
        lane_full = 4'd0;
        wait_pulse(1000, vec, at);
        check("model_lfsr_load", int'(lfsr_at[1]), 32'h59C3);
        check("model_lfsr_step4", int'(lfsr_at[4]), 32'hCE1E);
        check("first_pulse_cyc", at, 899);                 // 2 + (400+48)*2 + 1
        check("small_first_cyc", s_first_at, 235);         // 2 + (10+48)*4 + 1
        check("small_first_lane", int'(s_first_vec), int'(4'b0001 << lfsr_at[234][1:0]));

        // All lanes full for 20 intervals; play_flag drop must not stop the scheduler.
        lane_full = 4'b1111;
        play_flag = 1'b0;
        base = n_skipped;
        pulses = 0;
        busy_low = 0;
        for (int i = 0; i < 25000 && n_skipped < base + 20; i++) begin
            @(negedge Clk);
            if ({right_random, left_random, bottom_random, top_random} != 4'd0) pulses++;
            if (!spawn_busy) busy_low++;
        end
        check("full_intervals", n_skipped - base, 20);
        check("full_no_pulse", pulses, 0);
        check("full_level", int'(level), 0);
        check("full_busy_low", busy_low, 0);

        // Only the right lane free; walk the level up to 3.
        lane_full = 4'b0111;
        for (int n = 2; n <= 24; n++) begin
            wait_pulse(1200, vec, at);
            check("right_only", int'(vec), 8);
            @(negedge Clk);
            check($sformatf("level_after_%0d", n), int'(level), lvl_after(n));
        end

        // Level 3 with bottom and right free.
        lane_full = 4'b0101;
        for (int n = 0; n < 3; n++) begin
            wait_pulse(700, vec, at);
            check("burst_count", $countones(vec), BURST ? 2 : 1);
            check("burst_lanes", int'(vec & 4'b0101), 0);
        end

        // game_over coinciding with PICK drops the pulse and returns to IDLE.
        found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge Clk);
            if (m_active && cyc == pick_at) begin
                found = 1'b1;
                break;
            end
        end
        check("go_pick_found", int'(found), 1);
        game_over = 1'b1;
        @(negedge Clk);
        check("go_no_pulse", int'({right_random, left_random, bottom_random, top_random}), 0);
        check("go_busy", int'(spawn_busy), 0);
        check("go_level", int'(level), 0);
        game_over = 1'b0;
        repeat (40) @(negedge Clk);
        check("idle_stays", int'(spawn_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
